// File: rtl/sig_sink.sv
// sig_sink: compliance-signature sink on the core's data-store port.
// Stores to SIG_ADDR are queued in a FIFO and streamed out over a
// valid/ready port; a store to HALT_ADDR drains the FIFO, then raises done.
module sig_sink #(
  parameter logic [31:0] SIG_ADDR  = 32'h0000_0F00,
  parameter logic [31:0] HALT_ADDR = 32'hCAFE_BEEF,
  parameter int          DEPTH     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_en,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_ready,
  output logic        sig_valid,
  output logic [31:0] sig_data,
  input  logic        sig_ready,
  output logic        done,
  output logic        late_wr,
  output logic [15:0] word_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [31:0]   mem [DEPTH];
  logic          is_sig, is_halt;
  logic          full, empty;
  logic          push, pop;

  assign is_sig  = (st_addr == SIG_ADDR);
  assign is_halt = (st_addr == HALT_ADDR);

  // Extra pointer MSB separates full from empty when low bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Stall depends only on address and registered state, never on sig_ready,
  // so a full FIFO holds the store even when a pop happens this cycle.
  assign push = st_en && is_sig && st_ready && (state == RUN);
  assign pop  = sig_valid && sig_ready;

  assign sig_valid = !empty;
  assign sig_data  = mem[rd_ptr[AW-1:0]];

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  // Next-state and state-decoded outputs; DRAIN->DONE uses registered empty,
  // so a final pop at edge N moves to DONE at edge N+1.
  always_comb begin
    state_nxt = state;
    st_ready  = 1'b1;
    done      = 1'b0;
    unique case (state)
      RUN: begin
        st_ready = !(full && is_sig);
        if (st_en && is_halt) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (empty) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  // FIFO pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage; contents are meaningless once pointers reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= st_data;
  end

  // Sticky flag for signature stores that arrive after the halt
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   late_wr <= 1'b0;
    else if (st_en && is_sig && state != RUN)   late_wr <= 1'b1;
  end

  // Delivered-word counter, saturating
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             word_cnt <= '0;
    else if (pop && word_cnt != 16'hFFFF) word_cnt <= word_cnt + 16'd1;
  end

endmodule

// File: tb/tb_sig_sink.sv
// tb_sig_sink: random + directed stimulus, reference model with a queue,
// negedge monitor comparing every DUT output against the model.
module tb_sig_sink;

  localparam logic [31:0] SIG  = 32'h0000_0F00;
  localparam logic [31:0] HALT = 32'hCAFE_BEEF;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        st_en = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic        st_ready;
  logic        sig_valid;
  logic [31:0] sig_data;
  logic        sig_ready = 1'b0;
  logic        done;
  logic        late_wr;
  logic [15:0] word_cnt;

  int vectors = 0;
  int fails   = 0;

  sig_sink #(.SIG_ADDR(SIG), .HALT_ADDR(HALT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .st_en(st_en), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready), .sig_valid(sig_valid), .sig_data(sig_data),
    .sig_ready(sig_ready), .done(done), .late_wr(late_wr), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: queue of words the host has yet to receive, plus flags.
  logic [31:0] exp_q[$];
  bit          m_halted, m_done, m_late;
  int          m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      m_halted = 0; m_done = 0; m_late = 0; m_cnt = 0;
    end else begin
      bit is_sig, is_halt, was_empty, do_pop, do_push;
      is_sig    = st_en && st_addr == SIG;
      is_halt   = st_en && st_addr == HALT;
      was_empty = exp_q.size() == 0;
      do_pop    = !was_empty && sig_ready;
      do_push   = is_sig && !m_halted && exp_q.size() < DEPTH;
      if (m_halted && was_empty) m_done = 1;
      if (is_sig && m_halted) m_late = 1;
      if (do_pop) begin
        void'(exp_q.pop_front());
        if (m_cnt < 65535) m_cnt++;
      end
      if (do_push) exp_q.push_back(st_data);
      if (is_halt) m_halted = 1;
    end
  end

  // Monitor: outputs sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("st_ready", 32'(st_ready),
          32'(!(exp_q.size() == DEPTH && st_addr == SIG && !m_halted)));
      chk("sig_valid", 32'(sig_valid), 32'(exp_q.size() != 0));
      if (sig_valid && exp_q.size() != 0) chk("sig_data", sig_data, exp_q[0]);
      chk("done", 32'(done), 32'(m_done));
      chk("late_wr", 32'(late_wr), 32'(m_late));
      chk("word_cnt", 32'(word_cnt), 32'(m_cnt));
    end
  end

  // Issue one store at posedge+1 and hold it until accepted (bounded).
  task automatic store(input logic [31:0] a, input logic [31:0] d, input bit rnd_rdy);
    bit acc = 0;
    st_en = 1'b1; st_addr = a; st_data = d;
    for (int i = 0; i < 60 && !acc; i++) begin
      @(negedge clk); acc = st_ready;
      @(posedge clk); #1;
      if (rnd_rdy) sig_ready = ($urandom % 4) != 0;
    end
    if (!acc) begin
      fails++;
      $display("FAIL store_timeout: addr %h not accepted, st_ready stuck %b", a, st_ready);
    end
    st_en = 1'b0; st_addr = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b0;
    idle(2); rst = 1'b1;
    idle(1);
  endtask

  initial begin
    idle(2); rst = 1'b1; idle(1);
    chk("reset_st_ready", 32'(st_ready), 32'd1);
    chk("reset_sig_valid", 32'(sig_valid), 32'd0);

    // Basic in-order delivery
    sig_ready = 1'b1;
    store(SIG, 32'h11, 0); store(SIG, 32'h22, 0); store(SIG, 32'h33, 0);
    idle(3);
    chk("basic_word_cnt", 32'(word_cnt), 32'd3);

    // Backpressure: ninth store stalls until the first pop
    sig_ready = 1'b0;
    fork
      for (int i = 1; i <= 9; i++) store(SIG, 32'(i), 0);
      begin idle(14); sig_ready = 1'b1; end
    join
    idle(12);
    chk("bp_word_cnt", 32'(word_cnt), 32'd12);

    // Halt with words queued: done waits for the drain
    sig_ready = 1'b0;
    for (int i = 0; i < 4; i++) store(SIG, 32'hA0 + 32'(i), 0);
    store(HALT, 32'h0, 0);
    idle(4);
    chk("halt_done_held", 32'(done), 32'd0);
    sig_ready = 1'b1;
    idle(6);
    chk("halt_done", 32'(done), 32'd1);

    // Late write after halt is dropped and flagged
    store(SIG, 32'hDEAD, 0);
    store(HALT, 32'h1, 0);
    idle(2);
    chk("late_wr", 32'(late_wr), 32'd1);
    chk("late_cnt", 32'(word_cnt), 32'd16);

    // Halt with empty FIFO
    do_reset();
    store(HALT, 32'h0, 0);
    idle(3);
    chk("empty_halt_done", 32'(done), 32'd1);

    // Ignored addresses interleaved with signature stores, popping every cycle
    do_reset();
    sig_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      store(32'h1000, $urandom, 0);
      store(SIG, $urandom, 0);
      chk("occ_le1", 32'(exp_q.size() <= 1), 32'd1);
    end
    idle(3);

    // Random traffic with random backpressure, then halt
    do_reset();
    for (int i = 0; i < 300; i++) begin
      int k;
      logic [31:0] a;
      k = $urandom_range(0, 9);
      a = (k < 6) ? SIG : (k < 8) ? 32'h0000_0F04 : $urandom;
      if (a == HALT) a = 32'h4;
      sig_ready = ($urandom % 3) != 0;
      if ($urandom % 4 == 0) idle(1);
      else store(a, $urandom, 1);
    end
    store(HALT, 32'h0, 1);
    sig_ready = 1'b1;
    idle(DEPTH + 4);
    chk("rand_done", 32'(done), 32'd1);

    // Async reset mid-stream, between edges
    do_reset();
    sig_ready = 1'b0;
    for (int i = 0; i < 5; i++) store(SIG, 32'hB0 + 32'(i), 0);
    sig_ready = 1'b1;
    idle(2);
    #2 rst = 1'b0;
    #1;
    chk("arst_sig_valid", 32'(sig_valid), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_word_cnt", 32'(word_cnt), 32'd0);
    chk("arst_late_wr", 32'(late_wr), 32'd0);
    idle(2); rst = 1'b1; idle(1);
    store(SIG, 32'h11, 0); store(SIG, 32'h22, 0); store(SIG, 32'h33, 0);
    idle(3);
    chk("post_rst_cnt", 32'(word_cnt), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
